// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state encoding and prescaler sizing helpers for the stopwatch controller
package stopwatch_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_LAP     = 2'b11
  } state_t;
  function automatic int div_of(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction
  function automatic int presc_w(input int div);
    return $clog2(div);
  endfunction
endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// btn_edge: 2-flop synchronizer plus registered rising-edge detect producing a one-cycle press pulse
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  logic [2:0] sh;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sh    <= '0;
      pulse <= 1'b0;
    end else begin
      sh    <= {sh[1:0], btn};
      pulse <= sh[1] & ~sh[2];
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/lap/clear sequencer with tick prescaler.
// Define STOPWATCH_LAP_EN to enable the LAP state and display freeze.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap_clear,
  input  logic       at_max,
  output logic       count_en,
  output logic       count_clr,
  output logic       lap_load,
  output logic       disp_hold,
  output logic [1:0] state,
  output logic       running
);
  localparam int DIV = div_of(CLK_HZ, TICK_HZ);
  localparam int PW  = presc_w(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  state_t        st, nxt;
  logic [PW-1:0] presc, presc_n;
  logic          ss, lc, tick, active, clr_n;
  btn_edge u_ss (.clk(clk), .reset(reset), .btn(btn_start_stop), .pulse(ss));
  btn_edge u_lc (.clk(clk), .reset(reset), .btn(btn_lap_clear),  .pulse(lc));
  assign tick     = presc == LAST;
  assign active   = st == ST_RUNNING || st == ST_LAP;
  assign count_en = tick & active & ~at_max;
  assign running  = active;
  assign state    = st;
  // start_stop is tested first everywhere so a simultaneous lap_clear is dropped
  always_comb begin
    nxt   = st;
    clr_n = 1'b0;
    case (st)
      ST_IDLE:
        if (ss) nxt = ST_RUNNING;
        else if (lc) clr_n = 1'b1;
      ST_RUNNING:
        if (ss || (tick && at_max)) nxt = ST_PAUSED;
`ifdef STOPWATCH_LAP_EN
        else if (lc) nxt = ST_LAP;
      ST_LAP:
        if (ss || (tick && at_max)) nxt = ST_PAUSED;
        else if (lc) nxt = ST_RUNNING;
`endif
      ST_PAUSED:
        if (ss) nxt = at_max ? ST_PAUSED : ST_RUNNING;
        else if (lc) begin
          nxt   = ST_IDLE;
          clr_n = 1'b1;
        end
      default: nxt = ST_IDLE;
    endcase
    presc_n = (st == ST_IDLE || nxt == ST_IDLE) ? '0 :
              active ? (tick ? '0 : presc + 1'b1) : presc;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st        <= ST_IDLE;
      presc     <= '0;
      count_clr <= 1'b0;
    end else begin
      st        <= nxt;
      presc     <= presc_n;
      count_clr <= clr_n;
    end
`ifdef STOPWATCH_LAP_EN
  assign disp_hold = st == ST_LAP;
  always_ff @(posedge clk or posedge reset)
    if (reset) lap_load <= 1'b0;
    else lap_load <= nxt == ST_LAP && st != ST_LAP;
`else
  assign disp_hold = 1'b0;
  assign lap_load  = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of the stopwatch sequencer with DIV=10
module tb_stopwatch_ctrl;
  logic       clk = 1'b0, reset = 1'b1;
  logic       btn_start_stop = 1'b0, btn_lap_clear = 1'b0, at_max = 1'b0;
  logic       count_en, count_clr, lap_load, disp_hold, running;
  logic [1:0] state;
  int         n_tests = 0, n_fail = 0;
  int         k;
  logic       seen;
  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk(clk), .reset(reset), .btn_start_stop(btn_start_stop), .btn_lap_clear(btn_lap_clear),
    .at_max(at_max), .count_en(count_en), .count_clr(count_clr), .lap_load(lap_load),
    .disp_hold(disp_hold), .state(state), .running(running)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // button first sampled at edge N, state visible after edge N+3
  task automatic press(input logic s, input logic l);
    btn_start_stop = s;
    btn_lap_clear  = l;
    repeat (3) step();
    btn_start_stop = 1'b0;
    btn_lap_clear  = 1'b0;
    step();
  endtask
  task automatic next_en(output int d);
    d = 0;
    do begin
      step();
      d++;
    end while (!count_en && d < 40);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_en"}, count_en, 0);
    chk({tag, "_clr"}, count_clr, 0);
    chk({tag, "_load"}, lap_load, 0);
    chk({tag, "_hold"}, disp_hold, 0);
    chk({tag, "_run"}, running, 0);
  endtask
  initial begin
    repeat (2) step();
    chk_zero("rst");
    reset = 1'b0;
    step();
    press(1'b0, 1'b1);
    chk("idle_clr_state", state, 0);
    chk("idle_clr_pulse", count_clr, 1);
    step();
    chk("idle_clr_done", count_clr, 0);
    btn_start_stop = 1'b1;
    repeat (3) step();
    chk("start_n2", state, 0);
    btn_start_stop = 1'b0;
    step();
    chk("start_n3", state, 1);
    chk("start_run", running, 1);
    chk("start_en0", count_en, 0);
    next_en(k);
    chk("first_en", k, 9);
    next_en(k);
    chk("period_en", k, 10);
    // prescaler 9 now; 6 steps -> 5, pause lands with it held at 9
    repeat (6) step();
    press(1'b1, 1'b0);
    chk("pause_state", state, 2);
    chk("pause_en", count_en, 0);
    seen = 1'b0;
    repeat (50) begin
      step();
      seen |= count_en;
    end
    chk("paused_no_en", seen, 0);
    press(1'b1, 1'b0);
    chk("resume_state", state, 1);
    chk("resume_en", count_en, 1);
    next_en(k);
    chk("resume_period", k, 10);
    step();
    at_max = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      seen |= count_en;
      step();
    end
    chk("max_no_en", seen, 0);
    chk("max_paused", state, 2);
    press(1'b1, 1'b0);
    chk("max_stay", state, 2);
    at_max = 1'b0;
    btn_start_stop = 1'b1;
    btn_lap_clear  = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      step();
      seen |= count_clr;
    end
    btn_start_stop = 1'b0;
    btn_lap_clear  = 1'b0;
    step();
    seen |= count_clr;
    chk("both_state", state, 1);
    chk("both_no_clr", seen, 0);
    press(1'b1, 1'b0);
    chk("repause", state, 2);
    press(1'b0, 1'b1);
    chk("clear_state", state, 0);
    chk("clear_pulse", count_clr, 1);
    step();
    chk("clear_done", count_clr, 0);
    press(1'b1, 1'b0);
`ifdef STOPWATCH_LAP_EN
    press(1'b0, 1'b1);
    chk("lap_state", state, 3);
    chk("lap_load", lap_load, 1);
    chk("lap_hold", disp_hold, 1);
    chk("lap_run", running, 1);
    step();
    chk("lap_load_once", lap_load, 0);
    next_en(k);
    chk("lap_counts", k <= 10, 1);
    press(1'b0, 1'b1);
    chk("unlap_state", state, 1);
    chk("unlap_hold", disp_hold, 0);
    press(1'b0, 1'b1);
    chk("relap_state", state, 3);
`else
    press(1'b0, 1'b1);
    chk("nolap_state", state, 1);
    chk("nolap_load", lap_load, 0);
    chk("nolap_hold", disp_hold, 0);
`endif
    #2 reset = 1'b1;
    #1 chk_zero("midrst");
    step();
    reset = 1'b0;
    press(1'b1, 1'b0);
    chk("post_rst_state", state, 1);
    next_en(k);
    chk("post_rst_first_en", k, 9);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
